// File: rtl/jk_bank_arbiter_if.sv
// Request/command bus between JK requesters and jk_bank_arbiter.
// Requesters use the master modport; the arbiter uses the slave modport.
interface jk_bank_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int REQS  = 4
);
    localparam int AW = $clog2(WIDTH);
    localparam int GW = $clog2(REQS);

    logic [REQS-1:0]    req;
    logic [2*REQS-1:0]  cmd;
    logic [AW*REQS-1:0] addr;
    logic [REQS-1:0]    ack;
    logic [WIDTH-1:0]   j_out;
    logic [WIDTH-1:0]   k_out;
    logic [WIDTH-1:0]   en_out;
    logic [WIDTH-1:0]   q;
    logic               busy;
    logic [GW-1:0]      gnt_id;

    modport master (
        output req, cmd, addr,
        input  ack, j_out, k_out, en_out, q, busy, gnt_id
    );

    modport slave (
        input  req, cmd, addr,
        output ack, j_out, k_out, en_out, q, busy, gnt_id
    );
endinterface

// File: rtl/jk_bank_arbiter.sv
// Arbitrated setup/strobe/hold sequencer for a bank of JK cells.
// Define JK_ARB_FIXED_PRI_EN for fixed priority instead of round-robin.
module jk_bank_arbiter #(
    parameter int WIDTH = 8,
    parameter int REQS  = 4,
    localparam int AW   = $clog2(WIDTH),
    localparam int GW   = $clog2(REQS)
) (
    input logic clk,
    input logic rst_n,
    jk_bank_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    state_t           state;
    logic [1:0]       cmd_r;
    logic [AW-1:0]    addr_r;
    logic [GW-1:0]    gnt_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] j_r;
    logic [WIDTH-1:0] k_r;
    logic [WIDTH-1:0] en_r;
    logic [REQS-1:0]  ack_r;

    logic [GW-1:0]    start;
    logic [GW-1:0]    win;
    logic [1:0]       win_cmd;
    logic [AW-1:0]    win_addr;
    logic [WIDTH-1:0] win_sel;
    logic [WIDTH-1:0] sel_r;

    // Out-of-range addresses decode to an all-zero mask.
    function automatic logic [WIDTH-1:0] decode(input logic [AW-1:0] a);
        logic [WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (a == AW'(i)) m[i] = 1'b1;
        end
        return m;
    endfunction

`ifdef JK_ARB_FIXED_PRI_EN
    assign start = '0;
`else
    logic [GW-1:0] rr_ptr;
    assign start = rr_ptr;
`endif

    always_comb begin
        logic found;
        int   idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < REQS; i++) begin
            idx = int'(start) + i;
            if (idx >= REQS) idx = idx - REQS;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = GW'(idx);
            end
        end
    end

    assign win_cmd  = bus.cmd[2*int'(win) +: 2];
    assign win_addr = bus.addr[AW*int'(win) +: AW];
    assign win_sel  = decode(win_addr);
    assign sel_r    = decode(addr_r);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cmd_r  <= '0;
            addr_r <= '0;
            gnt_r  <= '0;
            q_r    <= '0;
            j_r    <= '0;
            k_r    <= '0;
            en_r   <= '0;
            ack_r  <= '0;
`ifndef JK_ARB_FIXED_PRI_EN
            rr_ptr <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (|bus.req) begin
                        state  <= SETUP;
                        cmd_r  <= win_cmd;
                        addr_r <= win_addr;
                        gnt_r  <= win;
                        j_r    <= win_cmd[1] ? win_sel : '0;
                        k_r    <= win_cmd[0] ? win_sel : '0;
`ifndef JK_ARB_FIXED_PRI_EN
                        if (int'(win) == REQS - 1) rr_ptr <= '0;
                        else                       rr_ptr <= win + 1'b1;
`endif
                    end
                end
                SETUP: begin
                    en_r  <= sel_r;
                    state <= STROBE;
                end
                STROBE: begin
                    en_r  <= '0;
                    ack_r <= REQS'(1) << gnt_r;
                    // Toggle uses the registered old value, so no oscillation.
                    unique case (cmd_r)
                        2'b00: q_r <= q_r;
                        2'b01: q_r <= q_r & ~sel_r;
                        2'b10: q_r <= q_r | sel_r;
                        2'b11: q_r <= q_r ^ sel_r;
                    endcase
                    state <= HOLD;
                end
                HOLD: begin
                    ack_r <= '0;
                    j_r   <= '0;
                    k_r   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ack    = ack_r;
    assign bus.j_out  = j_r;
    assign bus.k_out  = k_r;
    assign bus.en_out = en_r;
    assign bus.q      = q_r;
    assign bus.busy   = (state != IDLE);
    assign bus.gnt_id = gnt_r;

endmodule
